// File: rtl/lsu_axi_master_if.sv
// Bundle of core request/response and AXI-lite style bus signals for the LSU master.
interface lsu_axi_master_if;
   // core request / response
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [31:0] reqAddr;
   logic [1:0]  reqSize;
   logic        reqSigned;
   logic [31:0] reqWdata;
   logic        respValid;
   logic        respReady;
   logic [31:0] respRdata;
   logic        respErr;
   // read address / data
   logic [31:0] arAddr;
   logic [31:0] arWidth;
   logic        arValid;
   logic        arReady;
   logic [31:0] rData;
   logic        rValid;
   logic        rReady;
   // write address / data / response
   logic [31:0] awAddr;
   logic [1:0]  awPort;
   logic        awValid;
   logic        awReady;
   logic [31:0] wData;
   logic [3:0]  wStrb;
   logic        wValid;
   logic        wReady;
   logic [1:0]  bResp;
   logic        bValid;
   logic        bReady;
   // status
   logic        timeoutFlag;

   modport master (
      input  reqValid, reqWrite, reqAddr, reqSize, reqSigned, reqWdata, respReady,
             arReady, rData, rValid, awReady, wReady, bResp, bValid,
      output reqReady, respValid, respRdata, respErr, arAddr, arWidth, arValid, rReady,
             awAddr, awPort, awValid, wData, wStrb, wValid, bReady, timeoutFlag
   );

   modport slave (
      output reqValid, reqWrite, reqAddr, reqSize, reqSigned, reqWdata, respReady,
             arReady, rData, rValid, awReady, wReady, bResp, bValid,
      input  reqReady, respValid, respRdata, respErr, arAddr, arWidth, arValid, rReady,
             awAddr, awPort, awValid, wData, wStrb, wValid, bReady, timeoutFlag
   );
endinterface

// File: rtl/lsu_axi_master.sv
// Load/store unit bus master: one outstanding transaction, core request in,
// single-beat read or write on the bus, extended response back to the core.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a core request (reqReady=1)
// AR    | read address presented, waiting for arReady
// R     | rReady high, waiting for read data
// AWW   | write address and write data presented, independent handshakes
// B     | bReady high, waiting for write response
// RESP  | response presented to core until respReady
module lsu_axi_master #(
   parameter int TIMEOUT = 1024
) (
   input logic              clk,
   input logic              reset,
   lsu_axi_master_if.master bus
);

   typedef enum logic [2:0] {IDLE, AR, R, AWW, B, RESP} state_t;

   state_t      state;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [15:0] wait_cnt;
   logic        aw_fin;
   logic        w_fin;
   logic        in_wait;

   function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] sz,
                                               input logic sgn);
      case (sz)
         2'd0:    load_extend = {{24{sgn & d[7]}}, d[7:0]};
         2'd1:    load_extend = {{16{sgn & d[15]}}, d[15:0]};
         default: load_extend = d;
      endcase
   endfunction

   function automatic logic [3:0] store_strb(input logic [1:0] sz);
      case (sz)
         2'd0:    store_strb = 4'b0001;
         2'd1:    store_strb = 4'b0011;
         default: store_strb = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] access_width(input logic [1:0] sz);
      case (sz)
         2'd0:    access_width = 32'd8;
         2'd1:    access_width = 32'd16;
         default: access_width = 32'd32;
      endcase
   endfunction

   assign bus.reqReady = (state == IDLE);

   // A channel counts as finished once its valid has dropped or is handshaking now.
   assign aw_fin  = !bus.awValid || bus.awReady;
   assign w_fin   = !bus.wValid  || bus.wReady;
   assign in_wait = (state == AR) || (state == R) || (state == AWW) || (state == B);

   // Per-transaction wait counter; timeoutFlag is sticky and never aborts the transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt        <= '0;
         bus.timeoutFlag <= 1'b0;
      end else if (bus.reqValid && state == IDLE) begin
         wait_cnt <= '0;
      end else if (in_wait) begin
         if (wait_cnt != '1)
            wait_cnt <= wait_cnt + 16'd1;
         if (({1'b0, wait_cnt} + 17'd1) >= 17'(TIMEOUT))
            bus.timeoutFlag <= 1'b1;
      end
   end

   // Transaction FSM with registered bus and response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         req_size      <= 2'd0;
         req_signed    <= 1'b0;
         bus.arValid   <= 1'b0;
         bus.arAddr    <= '0;
         bus.arWidth   <= '0;
         bus.rReady    <= 1'b0;
         bus.awValid   <= 1'b0;
         bus.awAddr    <= '0;
         bus.awPort    <= 2'b00;
         bus.wValid    <= 1'b0;
         bus.wData     <= '0;
         bus.wStrb     <= 4'b0000;
         bus.bReady    <= 1'b0;
         bus.respValid <= 1'b0;
         bus.respRdata <= '0;
         bus.respErr   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.reqValid) begin
                  req_size   <= bus.reqSize;
                  req_signed <= bus.reqSigned;
                  if (bus.reqSize == 2'd3) begin
                     bus.respValid <= 1'b1;
                     bus.respErr   <= 1'b1;
                     bus.respRdata <= '0;
                     state         <= RESP;
                  end else if (bus.reqWrite) begin
                     bus.awValid <= 1'b1;
                     bus.awAddr  <= bus.reqAddr;
                     bus.awPort  <= 2'b00;
                     bus.wValid  <= 1'b1;
                     bus.wData   <= bus.reqWdata;
                     bus.wStrb   <= store_strb(bus.reqSize);
                     state       <= AWW;
                  end else begin
                     bus.arValid <= 1'b1;
                     bus.arAddr  <= bus.reqAddr;
                     bus.arWidth <= access_width(bus.reqSize);
                     state       <= AR;
                  end
               end
            end
            AR: begin
               if (bus.arReady) begin
                  bus.arValid <= 1'b0;
                  bus.rReady  <= 1'b1;
                  state       <= R;
               end
            end
            R: begin
               if (bus.rValid) begin
                  bus.rReady    <= 1'b0;
                  bus.respRdata <= load_extend(bus.rData, req_size, req_signed);
                  bus.respErr   <= 1'b0;
                  bus.respValid <= 1'b1;
                  state         <= RESP;
               end
            end
            AWW: begin
               if (bus.awValid && bus.awReady)
                  bus.awValid <= 1'b0;
               if (bus.wValid && bus.wReady)
                  bus.wValid <= 1'b0;
               if (aw_fin && w_fin) begin
                  bus.bReady <= 1'b1;
                  state      <= B;
               end
            end
            B: begin
               if (bus.bValid) begin
                  bus.bReady    <= 1'b0;
                  bus.respErr   <= (bus.bResp != 2'b00);
                  bus.respRdata <= '0;
                  bus.respValid <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (bus.respReady) begin
                  bus.respValid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Scoreboard bench for lsu_axi_master: directed and random loads/stores against
// a configurable-latency slave, expected responses derived from access rules.
module tb_lsu_axi_master;
   localparam int TO = 8;

   logic clk;
   logic reset;

   lsu_axi_master_if bif();

   lsu_axi_master #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          hold;
      logic        flag;
   } resp_t;
   typedef struct {
      logic [31:0] addr;
      logic [31:0] width;
   } ar_t;
   typedef struct {
      logic [31:0] data;
      logic [3:0]  strb;
   } w_t;

   resp_t       resp_q[$];
   ar_t         ar_q[$];
   logic [31:0] aw_q[$];
   w_t          w_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // slave behaviour for the current transaction
   int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0, resp_dly = 0;
   logic [31:0] slv_rdata = '0;
   logic [1:0]  slv_bresp = 2'b00;

   bit exp_flag = 1'b0;
   int n_ar_exp = 0, n_st_exp = 0;
   int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // reference: keep the low 8<<sz bits, interpret as signed if requested
   function automatic logic [31:0] ref_load(input logic [31:0] d, input int sz, input bit sgn);
      longint bits, v, m;
      bits = longint'(8 << sz);
      m    = longint'(1) << bits;
      v    = longint'(d) % m;
      if (sgn && v >= (m / 2))
         v = v - m;
      return 32'(v);
   endfunction

   // ---------------- slave models ----------------
   initial begin
      int n = 0;
      bif.arReady = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (reset || !bif.arValid) begin n = 0; bif.arReady = 1'b0; end
         else begin bif.arReady = (n >= ar_dly); n++; end
      end
   end

   initial begin
      int n = 0;
      bif.rValid = 1'b0;
      bif.rData  = '0;
      forever begin
         @(posedge clk); #1;
         if (reset || !bif.rReady) begin n = 0; bif.rValid = 1'b0; bif.rData = $urandom; end
         else begin
            bif.rValid = (n >= r_dly);
            bif.rData  = bif.rValid ? slv_rdata : $urandom;
            n++;
         end
      end
   end

   initial begin
      int n = 0;
      bif.awReady = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (reset || !bif.awValid) begin n = 0; bif.awReady = 1'b0; end
         else begin bif.awReady = (n >= aw_dly); n++; end
      end
   end

   initial begin
      int n = 0;
      bif.wReady = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (reset || !bif.wValid) begin n = 0; bif.wReady = 1'b0; end
         else begin bif.wReady = (n >= w_dly); n++; end
      end
   end

   initial begin
      int n = 0;
      bif.bValid = 1'b0;
      bif.bResp  = 2'b00;
      forever begin
         @(posedge clk); #1;
         if (reset || !bif.bReady) begin n = 0; bif.bValid = 1'b0; bif.bResp = 2'($urandom); end
         else begin
            bif.bValid = (n >= b_dly);
            bif.bResp  = bif.bValid ? slv_bresp : 2'($urandom);
            n++;
         end
      end
   end

   initial begin
      int n = 0;
      bif.respReady = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (reset || !bif.respValid) begin n = 0; bif.respReady = 1'b0; end
         else begin bif.respReady = (n >= resp_dly); n++; end
      end
   end

   // ---------------- monitor ----------------
   initial begin
      int          acc_cyc = 0;
      int          hold = 0;
      bit          in_resp = 0;
      bit          aw_prev_hs = 0, w_prev_hs = 0, aw_prev_v = 0, r_wait_prev = 0;
      logic [31:0] r_rd = '0;
      logic        r_err = 1'b0;
      resp_t       e;
      ar_t         a;
      w_t          w;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_resp = 0; aw_prev_hs = 0; w_prev_hs = 0; aw_prev_v = 0; r_wait_prev = 0;
         end else begin
            if (bif.reqValid && bif.reqReady) acc_cyc = cyc;

            if (aw_prev_hs) chk("aw_drop_after_hs", {31'd0, bif.awValid}, 32'd0);
            if (w_prev_hs)  chk("w_drop_after_hs", {31'd0, bif.wValid}, 32'd0);
            if (r_wait_prev) chk("rready_held", {31'd0, bif.rReady}, 32'd1);
            if (bif.awValid && !aw_prev_v) chk("aw_w_same_cycle", {31'd0, bif.wValid}, 32'd1);
            aw_prev_v   = bif.awValid;
            aw_prev_hs  = bif.awValid && bif.awReady;
            w_prev_hs   = bif.wValid && bif.wReady;
            r_wait_prev = bif.rReady && !bif.rValid;

            if (bif.arValid && bif.arReady) begin
               n_ar++;
               if (ar_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
               else begin
                  a = ar_q.pop_front();
                  chk("ar_addr", bif.arAddr, a.addr);
                  chk("ar_width", bif.arWidth, a.width);
               end
            end
            if (bif.awValid && bif.awReady) begin
               n_aw++;
               if (aw_q.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
               else begin
                  chk("aw_addr", bif.awAddr, aw_q.pop_front());
                  chk("aw_port", {30'd0, bif.awPort}, 32'd0);
               end
            end
            if (bif.wValid && bif.wReady) begin
               n_w++;
               if (w_q.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
               else begin
                  w = w_q.pop_front();
                  chk("w_data", bif.wData, w.data);
                  chk("w_strb", {28'd0, bif.wStrb}, {28'd0, w.strb});
               end
            end
            if (bif.bValid && bif.bReady) n_b++;

            if (bif.respValid) begin
               if (resp_q.size() == 0) begin
                  chk("resp_unexpected", 32'd1, 32'd0);
               end else begin
                  if (!in_resp) begin
                     in_resp = 1; hold = 0;
                     r_rd = bif.respRdata; r_err = bif.respErr;
                     chk("resp_latency", 32'(cyc - (acc_cyc + 1)), 32'(resp_q[0].lat));
                  end else begin
                     chk("resp_rdata_stable", bif.respRdata, r_rd);
                     chk("resp_err_stable", {31'd0, bif.respErr}, {31'd0, r_err});
                  end
                  hold++;
                  if (bif.respReady) begin
                     e = resp_q.pop_front();
                     in_resp = 0;
                     chk("resp_rdata", bif.respRdata, e.rdata);
                     chk("resp_err", {31'd0, bif.respErr}, {31'd0, e.err});
                     chk("resp_hold_cycles", 32'(hold), 32'(e.hold));
                     chk("timeout_flag", {31'd0, bif.timeoutFlag}, {31'd0, e.flag});
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic issue(input bit wr, input logic [31:0] addr, input int sz, input bit sgn,
                        input logic [31:0] wd);
      resp_t e;
      int    n;
      if (sz == 3) begin
         e.rdata = '0; e.err = 1'b1; e.lat = 0;
      end else if (!wr) begin
         e.rdata = ref_load(slv_rdata, sz, sgn); e.err = 1'b0;
         e.lat   = 2 + ar_dly + r_dly;
         ar_q.push_back('{addr, 32'(8 << sz)});
         n_ar_exp++;
      end else begin
         e.rdata = '0; e.err = (slv_bresp != 2'b00);
         e.lat   = 2 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
         aw_q.push_back(addr);
         w_q.push_back('{wd, 4'((1 << (1 << sz)) - 1)});
         n_st_exp++;
      end
      if (sz != 3 && e.lat >= TO) exp_flag = 1'b1;
      e.hold = resp_dly + 1;
      e.flag = exp_flag;
      resp_q.push_back(e);

      @(posedge clk); #1;
      bif.reqValid  = 1'b1;
      bif.reqWrite  = wr;
      bif.reqAddr   = addr;
      bif.reqSize   = 2'(sz);
      bif.reqSigned = sgn;
      bif.reqWdata  = wd;
      n = 0;
      do begin @(negedge clk); n++; end while (!bif.reqReady && n < 50);
      if (!bif.reqReady) chk("req_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      bif.reqValid  = 1'b0;
      bif.reqWrite  = 1'($urandom);
      bif.reqAddr   = $urandom;
      bif.reqSize   = 2'($urandom);
      bif.reqSigned = 1'($urandom);
      bif.reqWdata  = $urandom;
   endtask

   task automatic wait_done();
      int n = 0;
      while (resp_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
      if (resp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL resp_timeout: %0d responses outstanding, expected 0", resp_q.size());
         resp_q.delete();
      end
   endtask

   task automatic set_dly(input int a, input int r, input int aw, input int w, input int b,
                          input int rs);
      ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b; resp_dly = rs;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset         = 1'b1;
      bif.reqValid  = 1'b0;
      bif.reqWrite  = 1'b0;
      bif.reqAddr   = '0;
      bif.reqSize   = 2'd0;
      bif.reqSigned = 1'b0;
      bif.reqWdata  = '0;
      repeat (3) @(negedge clk);
      chk("rst_arValid", {31'd0, bif.arValid}, 32'd0);
      chk("rst_awValid", {31'd0, bif.awValid}, 32'd0);
      chk("rst_wValid", {31'd0, bif.wValid}, 32'd0);
      chk("rst_rReady", {31'd0, bif.rReady}, 32'd0);
      chk("rst_bReady", {31'd0, bif.bReady}, 32'd0);
      chk("rst_respValid", {31'd0, bif.respValid}, 32'd0);
      chk("rst_respRdata", bif.respRdata, 32'd0);
      chk("rst_respErr", {31'd0, bif.respErr}, 32'd0);
      chk("rst_timeoutFlag", {31'd0, bif.timeoutFlag}, 32'd0);
      chk("rst_arAddr", bif.arAddr, 32'd0);
      chk("rst_arWidth", bif.arWidth, 32'd0);
      chk("rst_awAddr", bif.awAddr, 32'd0);
      chk("rst_wData", bif.wData, 32'd0);
      chk("rst_wStrb", {28'd0, bif.wStrb}, 32'd0);
      chk("rst_awPort", {30'd0, bif.awPort}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_release_reqReady", {31'd0, bif.reqReady}, 32'd1);

      // signed byte load
      set_dly(0, 0, 0, 0, 0, 0); slv_rdata = 32'h0000_0080;
      issue(1'b0, 32'h8000_0010, 0, 1'b1, 32'h0); wait_done();
      // unsigned half load with delayed read data
      set_dly(0, 5, 0, 0, 0, 0); slv_rdata = 32'h1234_F00D;
      issue(1'b0, 32'h0000_1002, 1, 1'b0, 32'h0); wait_done();
      // signed half, unsigned byte, word loads
      set_dly(1, 0, 0, 0, 0, 1); slv_rdata = 32'h0000_8001;
      issue(1'b0, 32'h0000_2000, 1, 1'b1, 32'h0); wait_done();
      set_dly(0, 1, 0, 0, 0, 0); slv_rdata = 32'hFFFF_FFF0;
      issue(1'b0, 32'h0000_2004, 0, 1'b0, 32'h0); wait_done();
      issue(1'b0, 32'h0000_2008, 2, 1'b1, 32'h0); wait_done();
      // word store, address accepted 3 cycles before data
      set_dly(0, 0, 0, 3, 0, 0); slv_bresp = 2'b00;
      issue(1'b1, 32'hA000_03F8, 2, 1'b0, 32'hDEAD_BEEF); wait_done();
      // byte store with error response, response held 4 cycles
      set_dly(0, 0, 1, 0, 1, 4); slv_bresp = 2'b10;
      issue(1'b1, 32'h0000_3001, 0, 1'b0, 32'h0000_00A5); wait_done();
      // half store, data before address
      set_dly(0, 0, 2, 0, 0, 0); slv_bresp = 2'b00;
      issue(1'b1, 32'h0000_3002, 1, 1'b0, 32'h0000_BEEF); wait_done();
      // illegal size, load and store
      set_dly(0, 0, 0, 0, 0, 0);
      issue(1'b0, 32'h0000_4000, 3, 1'b1, 32'h0); wait_done();
      issue(1'b1, 32'h0000_4004, 3, 1'b0, 32'h1234_5678); wait_done();
      @(negedge clk);
      chk("no_timeout_yet", {31'd0, bif.timeoutFlag}, 32'd0);
      // arReady stuck low 10 cycles with TIMEOUT=8
      set_dly(10, 0, 0, 0, 0, 0); slv_rdata = 32'h0BAD_F00D;
      issue(1'b0, 32'h0000_5000, 2, 1'b0, 32'h0); wait_done();
      @(negedge clk);
      chk("timeout_sticky", {31'd0, bif.timeoutFlag}, 32'd1);

      // random traffic
      for (int i = 0; i < 40; i++) begin
         int sz;
         set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         slv_rdata = $urandom;
         slv_bresp = 2'($urandom_range(0, 3));
         sz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
         issue(1'($urandom_range(0, 1)), $urandom, sz, 1'($urandom_range(0, 1)), $urandom);
         wait_done();
      end

      // reset while waiting in R
      set_dly(0, 20, 0, 0, 0, 0); slv_rdata = 32'h1111_2222;
      issue(1'b0, 32'h0000_6000, 2, 1'b0, 32'h0);
      n = 0;
      do begin @(negedge clk); n++; end while (!bif.rReady && n < 20);
      chk("reach_R_state", {31'd0, bif.rReady}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_arValid", {31'd0, bif.arValid}, 32'd0);
      chk("midrst_awValid", {31'd0, bif.awValid}, 32'd0);
      chk("midrst_wValid", {31'd0, bif.wValid}, 32'd0);
      chk("midrst_rReady", {31'd0, bif.rReady}, 32'd0);
      chk("midrst_bReady", {31'd0, bif.bReady}, 32'd0);
      chk("midrst_respValid", {31'd0, bif.respValid}, 32'd0);
      resp_q.delete();
      exp_flag = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_reqReady", {31'd0, bif.reqReady}, 32'd1);
      chk("midrst_flag_cleared", {31'd0, bif.timeoutFlag}, 32'd0);
      set_dly(0, 0, 0, 0, 0, 0); slv_rdata = 32'h0000_7FFF;
      issue(1'b0, 32'h0000_6004, 1, 1'b1, 32'h0); wait_done();

      repeat (3) @(negedge clk);
      chk("ar_handshakes", 32'(n_ar), 32'(n_ar_exp));
      chk("aw_handshakes", 32'(n_aw), 32'(n_st_exp));
      chk("w_handshakes", 32'(n_w), 32'(n_st_exp));
      chk("b_handshakes", 32'(n_b), 32'(n_st_exp));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
